// File: rtl/nvdla_hls_pipe_shift_round_sat.sv
// nvdla_hls_pipe_shift_round_sat: two-stage shift, round-half-away and saturate with valid/ready and saturation counter
module nvdla_hls_pipe_shift_round_sat #(
  parameter int IN_WIDTH    = 49,
  parameter int OUT_WIDTH   = 32,
  parameter int SHIFT_WIDTH = 6,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic                   in_pvld,
  output logic                   in_prdy,
  input  logic [IN_WIDTH-1:0]    in_data,
  input  logic [SHIFT_WIDTH-1:0] in_shift,
  input  logic                   in_unsigned,
  output logic                   out_pvld,
  input  logic                   out_prdy,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_sat,
  output logic [CNT_WIDTH-1:0]   sat_cnt,
  input  logic                   sat_cnt_clr
);
  logic [SHIFT_WIDTH-1:0] sh;
  logic [IN_WIDTH-1:0] half;
  logic signed [IN_WIDTH-1:0] q, r_next, s1_r;
  logic guide, sticky, rnd, s1_vld, s1_uns, s1_rdy, s2_rdy;
  logic neg, s_sat, u_over, sat;
  logic [OUT_WIDTH-1:0] sat_data;
  assign s2_rdy  = ~out_pvld | out_prdy;
  assign s1_rdy  = ~s1_vld | s2_rdy;
  assign in_prdy = s1_rdy | ~nvdla_core_rstn;
  // half selects the guard bit; the bits below it form the sticky mask (unused when sh=0)
  always_comb begin
    sh     = (int'(in_shift) > IN_WIDTH - 1) ? SHIFT_WIDTH'(IN_WIDTH - 1) : in_shift;
    half   = (IN_WIDTH'(1) << sh) >> 1;
    q      = $signed(in_data) >>> sh;
    guide  = |(in_data & half);
    sticky = |(in_data & (half - 1'b1));
    rnd    = guide & ~(in_data[IN_WIDTH-1] & ~sticky);
    r_next = q + IN_WIDTH'(rnd);
  end
  always_comb begin
    neg      = s1_r[IN_WIDTH-1];
    s_sat    = ~(&s1_r[IN_WIDTH-1:OUT_WIDTH-1] | ~|s1_r[IN_WIDTH-1:OUT_WIDTH-1]);
    u_over   = |s1_r[IN_WIDTH-2:OUT_WIDTH];
    sat      = s1_uns ? (neg | u_over) : s_sat;
    sat_data = s1_uns ? (neg ? '0 : u_over ? '1 : s1_r[OUT_WIDTH-1:0])
                      : (s_sat ? (neg ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}})
                               : s1_r[OUT_WIDTH-1:0]);
  end
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      s1_vld <= 1'b0;
    end else if (s1_rdy) begin
      s1_vld <= in_pvld;
      if (in_pvld) begin
        s1_r   <= r_next;
        s1_uns <= in_unsigned;
      end
    end
  end
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      out_pvld <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (s2_rdy) begin
      out_pvld <= s1_vld;
      if (s1_vld) begin
        out_data <= sat_data;
        out_sat  <= sat;
      end
    end
  end
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn || sat_cnt_clr)
      sat_cnt <= '0;
    else if (out_pvld && out_prdy && out_sat && !(&sat_cnt))
      sat_cnt <= sat_cnt + 1'b1;
  end
endmodule

// File: tb/tb_nvdla_hls_pipe_shift_round_sat.sv
// tb_nvdla_hls_pipe_shift_round_sat: directed vectors for shift/round/saturate, flow control and counter
module tb_nvdla_hls_pipe_shift_round_sat;
  localparam int IW = 49, OW = 32, SW = 6, CW = 3;
  logic clk = 0, rstn = 0, in_pvld = 0, in_unsigned = 0, out_prdy = 1, sat_cnt_clr = 0;
  logic in_prdy, out_pvld, out_sat, acc, xf;
  logic [IW-1:0] in_data = '0;
  logic [SW-1:0] in_shift = '0;
  logic [OW-1:0] out_data;
  logic [CW-1:0] sat_cnt;
  int checks = 0, errors = 0, sent = 0, recv = 0;
  always #5 clk = ~clk;
  nvdla_hls_pipe_shift_round_sat #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .in_pvld(in_pvld), .in_prdy(in_prdy),
    .in_data(in_data), .in_shift(in_shift), .in_unsigned(in_unsigned), .out_pvld(out_pvld),
    .out_prdy(out_prdy), .out_data(out_data), .out_sat(out_sat), .sat_cnt(sat_cnt),
    .sat_cnt_clr(sat_cnt_clr));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic beat(input string tag, input logic [IW-1:0] d, input logic [SW-1:0] sh, input logic u,
                      input logic [OW-1:0] ed, input logic es);
    in_pvld = 1; in_data = d; in_shift = sh; in_unsigned = u; out_prdy = 1;
    @(posedge clk); #1 in_pvld = 0;
    chk({tag, " early"}, out_pvld, 0);
    @(posedge clk); #1;
    chk({tag, " pvld"}, out_pvld, 1);
    chk({tag, " data"}, out_data, ed);
    chk({tag, " sat"}, out_sat, es);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst pvld", out_pvld, 0);
    chk("rst data", out_data, 0);
    chk("rst sat", out_sat, 0);
    chk("rst cnt", sat_cnt, 0);
    chk("rst prdy", in_prdy, 1);
    rstn = 1;
    beat("t1 256", 49'd256, 6'd4, 0, 32'd16, 0);
    beat("t1 24", 49'd24, 6'd4, 0, 32'd2, 0);
    beat("t1 -24", -49'sd24, 6'd4, 0, 32'hFFFF_FFFE, 0);
    beat("t1 -20", -49'sd20, 6'd4, 0, 32'hFFFF_FFFF, 0);
    beat("t1 -8", -49'sd8, 6'd4, 0, 32'hFFFF_FFFF, 0);
    beat("t2 pos", 49'h100_0000_0000, 6'd0, 0, 32'h7FFF_FFFF, 1);
    beat("t2 neg", -49'sh100_0000_0000, 6'd0, 0, 32'h8000_0000, 1);
    beat("t2 max", 49'h7FFF_FFFF, 6'd0, 0, 32'h7FFF_FFFF, 0);
    @(posedge clk); #1 chk("t2 cnt", sat_cnt, 2);
    beat("t3 neg", -49'sd5, 6'd1, 1, 32'd0, 1);
    beat("t3 fit", 49'h1_FFFF_FFFE, 6'd1, 1, 32'hFFFF_FFFF, 0);
    beat("t3 over", 49'h3_0000_0000, 6'd1, 1, 32'hFFFF_FFFF, 1);
    beat("t3 sh63", -49'sd1, 6'd63, 1, 32'd0, 0);
    @(posedge clk); #1 chk("t3 cnt", sat_cnt, 4);
    for (int cyc = 0; cyc < 60 && recv < 10; cyc++) begin
      out_prdy = (cyc % 2 == 0); in_pvld = (sent < 10); in_data = IW'(sent); in_shift = 0; in_unsigned = 0;
      #1;
      chk("t4 prdy", in_prdy, !((sent - recv) == 2 && !out_prdy));
      acc = in_pvld && in_prdy;
      xf = out_pvld && out_prdy;
      if (xf) begin
        chk("t4 data", out_data, recv);
        chk("t4 sat", out_sat, 0);
      end
      @(posedge clk); #1;
      if (acc) sent++;
      if (xf) recv++;
    end
    in_pvld = 0; out_prdy = 1;
    chk("t4 sent", sent, 10);
    chk("t4 recv", recv, 10);
    sat_cnt_clr = 1;
    @(posedge clk); #1 sat_cnt_clr = 0;
    chk("t5 clr", sat_cnt, 0);
    for (int i = 0; i < 9; i++) beat("t5 sat", 49'h100_0000_0000, 6'd0, 0, 32'h7FFF_FFFF, 1);
    @(posedge clk); #1 chk("t5 stick", sat_cnt, 7);
    beat("t5 last", 49'h100_0000_0000, 6'd0, 0, 32'h7FFF_FFFF, 1);
    sat_cnt_clr = 1;
    @(posedge clk); #1 sat_cnt_clr = 0;
    chk("t5 clr win", sat_cnt, 0);
    beat("t6 pre", 49'h100_0000_0000, 6'd0, 0, 32'h7FFF_FFFF, 1);
    @(posedge clk); #1 chk("t6 cnt", sat_cnt, 1);
    in_pvld = 1; in_data = 49'd1; in_shift = 0; out_prdy = 0;
    @(posedge clk); #1 in_data = 49'd2;
    @(posedge clk); #1 in_pvld = 0;
    chk("t6 full", out_pvld, 1);
    rstn = 0;
    @(posedge clk); #1;
    chk("t6 rst pvld", out_pvld, 0);
    chk("t6 rst cnt", sat_cnt, 0);
    chk("t6 rst prdy", in_prdy, 1);
    rstn = 1; out_prdy = 1;
    repeat (3) @(posedge clk);
    #1 chk("t6 flushed", out_pvld, 0);
    beat("t6 seven", 49'd7, 6'd0, 0, 32'd7, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
